counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised successor to the single free-running event counter: NUM_CH independent counters in one block.
- Per-cycle increment by a variable amount; runtime-selectable wrap or saturate at a programmable ceiling; registered read port with optional clear-on-read.
- Sits beside packet-processing stages as per-flow / per-port statistics storage.

Parameters:
- NUM_CH, 8, number of counter channels (>=2).
- CH_WIDTH, $clog2(NUM_CH), channel index width.
- COUNT_WIDTH, 32, bits per counter.
- AMT_WIDTH, 8, increment-amount width; must satisfy AMT_WIDTH <= COUNT_WIDTH.
- MAX_COUNT, 2**COUNT_WIDTH-1, ceiling value; must be >= 2**AMT_WIDTH-1.
- INIT_VALUE, 0, reset value of every channel.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- i__mode_sat  in  1  0 = wrap at MAX_COUNT, 1 = saturate at MAX_COUNT; sampled every cycle.
- i__inc_valid  in  1  increment request.
- i__inc_ch  in  CH_WIDTH  channel to increment.
- i__inc_amt  in  AMT_WIDTH  amount to add; 0 is legal (no change).
- i__rd_valid  in  1  read request.
- i__rd_ch  in  CH_WIDTH  channel to read.
- i__rd_clear  in  1  clear channel on read (qualified by i__rd_valid).
- o__rd_valid  out  1  read data valid, 1 cycle after request.
- o__rd_count  out  COUNT_WIDTH  read data.
- o__wrap  out  1  1-cycle pulse: last increment exceeded MAX_COUNT (wrapped or clipped).
- o__wrap_ch  out  CH_WIDTH  channel that caused o__wrap.

Behaviour:
- Reset (reset==0 at a clock edge): all channels <= INIT_VALUE; o__rd_valid, o__wrap <= 0; o__rd_count, o__wrap_ch <= 0. Request in flight during reset is dropped; no response after reset releases.
- Channel index >= NUM_CH: request ignored; a read still returns o__rd_valid=1 with o__rd_count=0.
- Increment arithmetic: sum = count + amt in COUNT_WIDTH+1 bits.
  - sum <= MAX_COUNT: next = sum.
  - sum > MAX_COUNT, wrap: next = sum - (MAX_COUNT+1); o__wrap pulses next cycle.
  - sum > MAX_COUNT, saturate: next = MAX_COUNT; o__wrap pulses next cycle.
  - Counter already equal to MAX_COUNT with amt=0 in saturate mode: no pulse.
- Increment update visible to a read issued the following cycle (single-cycle RMW, no hazard).
- Read: o__rd_count, o__rd_valid registered; value = channel contents at the request edge, i.e. pre-update, before any same-cycle increment.
- Clear-on-read: channel <= 0 at the same edge that captures read data.
- Same-cycle increment + clear-on-read, same channel: read returns old value; channel <= f(0 + amt) with the same wrap/sat rules. No event lost.
- Same-cycle increment + plain read, same channel: read returns old value; increment applied.
- Different channels: both operations independent, one cycle each; full throughput, no backpressure.

Optional Feature:
- COUNTER_BANK_STICKY_OVF_EN.
- Defined: adds output o__ovf_sticky [NUM_CH-1:0]. Bit set on any wrap/clip event for that channel. Cleared by reset or by a clear-on-read of that channel; a same-cycle event wins and the bit stays set. Reset value 0.
- Undefined: port and state absent; o__wrap/o__wrap_ch are the only overflow indication.

Decomposition:
- Package counter_bank_pkg:
  - mode typedef (CNT_MODE_WRAP=0, CNT_MODE_SAT=1).
  - default width constants.
  - parameter-legality check macros/constants.
- Sub-module counter_bank_add: combinational sum/wrap/saturate of one counter. Outputs next value and overflow flag; instantiated once on the increment path.
- Channel storage: flop array in the top level.

Test Plan:
- Reset: drive reset=0 with INIT_VALUE=5, then release; read ch 3 -> o__rd_count=5, o__rd_valid exactly 1 cycle later, o__wrap=0.
- Wrap: MAX_COUNT=255 (COUNT_WIDTH=8), mode 0, ch 2 = 250, inc amt 10 -> ch 2 = 4; o__wrap=1 for one cycle, o__wrap_ch=2.
- Saturate: same start, mode 1, inc 10 -> ch 2 = 255, o__wrap=1; further inc 0 -> 255, no pulse.
- Clear-on-read collision: ch 1 = 100; same cycle inc ch 1 amt 7 and read-clear ch 1 -> o__rd_count=100, next read of ch 1 returns 7.
- Back-to-back: incs every cycle on alternating ch 0/1 by 1 for 20 cycles, reads of both interleaved -> final values 10/10; every read shows pre-update value.
- Reset mid-read: read issued, reset=0 the next edge -> o__rd_valid stays 0; all channels return to INIT_VALUE.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types and constants for the counter_bank statistics block.
//   cnt_mode_e        : overflow handling mode (wrap / saturate).
//   Def*              : default widths used by counter_bank.
//   cnt_params_legal  : elaboration-time parameter legality check.
package counter_bank_pkg;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned DefNumCh      = 8;
  localparam int unsigned DefCountWidth = 32;
  localparam int unsigned DefAmtWidth   = 8;

  // max_ok carries the MAX_COUNT >= 2**AMT_WIDTH-1 comparison, which has to be done at the
  // counter width by the caller since it can exceed 32 bits.
  function automatic bit cnt_params_legal(input int unsigned num_ch,
                                          input int unsigned ch_width,
                                          input int unsigned count_width,
                                          input int unsigned amt_width,
                                          input bit          max_ok);
    return (num_ch >= 2) &&
           ((64'd1 << ch_width) >= 64'(num_ch)) &&
           (amt_width >= 1) &&
           (amt_width <= count_width) &&
           max_ok;
  endfunction

endpackage

// File: rtl/counter_bank_add.sv
// Combinational increment of one counter with wrap/saturate at a programmable ceiling.
// Ports:
//   count      in   current counter value
//   amt        in   amount to add (0 leaves the value unchanged)
//   mode_sat   in   0 = wrap past MAX_COUNT, 1 = clip at MAX_COUNT
//   next_count out  updated counter value
//   ovf        out  the sum exceeded MAX_COUNT (wrapped or clipped)
module counter_bank_add
  import counter_bank_pkg::*;
#(
  parameter int unsigned            COUNT_WIDTH = DefCountWidth,
  parameter int unsigned            AMT_WIDTH   = DefAmtWidth,
  parameter logic [COUNT_WIDTH-1:0] MAX_COUNT   = {COUNT_WIDTH{1'b1}}
) (
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [AMT_WIDTH-1:0]   amt,
  input  logic                   mode_sat,
  output logic [COUNT_WIDTH-1:0] next_count,
  output logic                   ovf
);

  localparam logic [COUNT_WIDTH:0] MaxWide = {1'b0, MAX_COUNT};

  logic [COUNT_WIDTH:0]   sum;
  logic [COUNT_WIDTH-1:0] wrapped;
  cnt_mode_e              mode;

  always_comb begin
    mode = cnt_mode_e'(mode_sat);
    sum  = {1'b0, count} + (COUNT_WIDTH+1)'(amt);
    ovf  = sum > MaxWide;
    // The true result of sum-(MAX_COUNT+1) is always below 2**COUNT_WIDTH, so modular
    // arithmetic on the low bits gives the exact value.
    wrapped    = sum[COUNT_WIDTH-1:0] - MAX_COUNT - COUNT_WIDTH'(1);
    next_count = sum[COUNT_WIDTH-1:0];
    if (ovf) begin
      unique case (mode)
        CNT_MODE_WRAP: next_count = wrapped;
        CNT_MODE_SAT:  next_count = MAX_COUNT;
      endcase
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent event counters for per-flow / per-port statistics.
// One increment and one read per cycle, no backpressure.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   i__mode_sat                0 = wrap at MAX_COUNT, 1 = saturate
//   i__inc_valid/ch/amt        increment request
//   i__rd_valid/ch/clear       read request, optional clear-on-read
//   o__rd_valid, o__rd_count   registered read response (pre-update value)
//   o__wrap, o__wrap_ch        one-cycle overflow pulse and its channel
//   o__ovf_sticky              per-channel sticky overflow flags
//                              (only when COUNTER_BANK_STICKY_OVF_EN is defined)
// Channel indices >= NUM_CH are ignored; such a read returns count 0.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned            NUM_CH      = DefNumCh,
  parameter int unsigned            CH_WIDTH    = $clog2(NUM_CH),
  parameter int unsigned            COUNT_WIDTH = DefCountWidth,
  parameter int unsigned            AMT_WIDTH   = DefAmtWidth,
  parameter logic [COUNT_WIDTH-1:0] MAX_COUNT   = {COUNT_WIDTH{1'b1}},
  parameter logic [COUNT_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i__mode_sat,
  input  logic                   i__inc_valid,
  input  logic [CH_WIDTH-1:0]    i__inc_ch,
  input  logic [AMT_WIDTH-1:0]   i__inc_amt,
  input  logic                   i__rd_valid,
  input  logic [CH_WIDTH-1:0]    i__rd_ch,
  input  logic                   i__rd_clear,
  output logic                   o__rd_valid,
  output logic [COUNT_WIDTH-1:0] o__rd_count,
  output logic                   o__wrap,
  output logic [CH_WIDTH-1:0]    o__wrap_ch
`ifdef COUNTER_BANK_STICKY_OVF_EN
  ,
  output logic [NUM_CH-1:0]      o__ovf_sticky
`endif
);

  localparam logic [COUNT_WIDTH:0] AmtMax = (COUNT_WIDTH+1)'({AMT_WIDTH{1'b1}});
  localparam bit                   MaxOk  = ({1'b0, MAX_COUNT} >= AmtMax);
  localparam logic [CH_WIDTH:0]    NumChW = (CH_WIDTH+1)'(NUM_CH);

  if (!cnt_params_legal(NUM_CH, CH_WIDTH, COUNT_WIDTH, AMT_WIDTH, MaxOk)) begin : g_param_check
    $error("counter_bank: illegal parameter set");
  end

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_CH];

  logic                   inc_hit, rd_hit, rd_clr_hit, collide;
  logic [CH_WIDTH-1:0]    inc_idx, rd_idx;
  logic [COUNT_WIDTH-1:0] add_base, add_next;
  logic                   add_ovf;

  logic                   rd_valid_q, rd_valid_d;
  logic [COUNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                   wrap_q, wrap_d;
  logic [CH_WIDTH-1:0]    wrap_ch_q, wrap_ch_d;

  // Out-of-range requests are dropped; indices are forced in range so no array read ever
  // goes past the end of the bank.
  always_comb begin
    inc_hit    = i__inc_valid && ({1'b0, i__inc_ch} < NumChW);
    rd_hit     = i__rd_valid && ({1'b0, i__rd_ch} < NumChW);
    rd_clr_hit = rd_hit && i__rd_clear;
    inc_idx    = inc_hit ? i__inc_ch : '0;
    rd_idx     = rd_hit ? i__rd_ch : '0;
    collide    = inc_hit && rd_clr_hit && (i__inc_ch == i__rd_ch);
    // A clear-on-read landing on the channel being incremented restarts from zero so the
    // increment is not lost.
    add_base   = collide ? '0 : cnt_q[inc_idx];
  end

  counter_bank_add #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .AMT_WIDTH   (AMT_WIDTH),
    .MAX_COUNT   (MAX_COUNT)
  ) u_add (
    .count      (add_base),
    .amt        (i__inc_amt),
    .mode_sat   (i__mode_sat),
    .next_count (add_next),
    .ovf        (add_ovf)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (rd_clr_hit) cnt_d[rd_idx] = '0;
    if (inc_hit)    cnt_d[inc_idx] = add_next;

    rd_valid_d = i__rd_valid;
    rd_count_d = rd_hit ? cnt_q[rd_idx] : '0;
    wrap_d     = inc_hit && add_ovf;
    wrap_ch_d  = wrap_d ? i__inc_ch : wrap_ch_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= INIT_VALUE;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      wrap_q     <= 1'b0;
      wrap_ch_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_count_q <= rd_count_d;
      wrap_q     <= wrap_d;
      wrap_ch_q  <= wrap_ch_d;
    end
  end

  assign o__rd_valid = rd_valid_q;
  assign o__rd_count = rd_count_q;
  assign o__wrap     = wrap_q;
  assign o__wrap_ch  = wrap_ch_q;

`ifdef COUNTER_BANK_STICKY_OVF_EN
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  // Set after clear so an overflow in the clearing cycle keeps the flag up.
  always_comb begin
    sticky_d = sticky_q;
    if (rd_clr_hit) sticky_d[rd_idx] = 1'b0;
    if (wrap_d)     sticky_d[inc_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign o__ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  localparam int NCH  = 6;
  localparam int MAXC = 255;
  localparam int INIT = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_sat;
  logic       inc_valid;
  logic [2:0] inc_ch;
  logic [7:0] inc_amt;
  logic       rd_valid;
  logic [2:0] rd_ch;
  logic       rd_clear;
  logic       rd_valid_o;
  logic [7:0] rd_count_o;
  logic       wrap_o;
  logic [2:0] wrap_ch_o;
`ifdef COUNTER_BANK_STICKY_OVF_EN
  logic [NCH-1:0] ovf_sticky_o;
`endif

  counter_bank #(
    .NUM_CH      (NCH),
    .COUNT_WIDTH (8),
    .AMT_WIDTH   (8),
    .MAX_COUNT   (8'd255),
    .INIT_VALUE  (8'd5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i__mode_sat  (mode_sat),
    .i__inc_valid (inc_valid),
    .i__inc_ch    (inc_ch),
    .i__inc_amt   (inc_amt),
    .i__rd_valid  (rd_valid),
    .i__rd_ch     (rd_ch),
    .i__rd_clear  (rd_clear),
    .o__rd_valid  (rd_valid_o),
    .o__rd_count  (rd_count_o),
    .o__wrap      (wrap_o),
    .o__wrap_ch   (wrap_ch_o)
`ifdef COUNTER_BANK_STICKY_OVF_EN
    ,
    .o__ovf_sticky (ovf_sticky_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integer counters and the expected response of the last edge.
  int m_cnt [NCH];
  bit m_sticky [NCH];
  bit primed = 1'b0;
  bit exp_rd_valid, exp_wrap;
  int exp_rd_count, exp_wrap_ch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks the response to the previous edge, then applies one cycle of stimulus and
  // advances the model across the coming edge.
  task automatic step(input bit rst_n, input bit mode, input bit iv, input int ich,
                      input int iamt, input bit rv, input int rch, input bit rclr);
    int sum;
    @(negedge clk);
    if (primed) begin
      check_eq("rd_valid", 32'(rd_valid_o), 32'(exp_rd_valid));
      if (exp_rd_valid) check_eq("rd_count", 32'(rd_count_o), exp_rd_count);
      check_eq("wrap", 32'(wrap_o), 32'(exp_wrap));
      if (exp_wrap) check_eq("wrap_ch", 32'(wrap_ch_o), exp_wrap_ch);
`ifdef COUNTER_BANK_STICKY_OVF_EN
      for (int c = 0; c < NCH; c++) check_eq("ovf_sticky", 32'(ovf_sticky_o[c]), 32'(m_sticky[c]));
`endif
    end
    reset     = rst_n;
    mode_sat  = mode;
    inc_valid = iv;
    inc_ch    = 3'(ich);
    inc_amt   = 8'(iamt);
    rd_valid  = rv;
    rd_ch     = 3'(rch);
    rd_clear  = rclr;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c]    = INIT;
        m_sticky[c] = 1'b0;
      end
      exp_rd_valid = 1'b0;
      exp_rd_count = 0;
      exp_wrap     = 1'b0;
      exp_wrap_ch  = 0;
      primed       = 1'b1;
    end else begin
      exp_rd_valid = rv;
      exp_rd_count = (rv && rch < NCH) ? m_cnt[rch] : 0;
      exp_wrap     = 1'b0;
      if (rv && rclr && rch < NCH) begin
        m_cnt[rch]    = 0;
        m_sticky[rch] = 1'b0;
      end
      if (iv && ich < NCH) begin
        sum = m_cnt[ich] + iamt;
        if (sum > MAXC) begin
          exp_wrap      = 1'b1;
          exp_wrap_ch   = ich;
          m_sticky[ich] = 1'b1;
          m_cnt[ich]    = mode ? MAXC : sum - (MAXC + 1);
        end else begin
          m_cnt[ich] = sum;
        end
      end
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic inc(input bit mode, input int ch, input int amt);
    step(1, mode, 1, ch, amt, 0, 0, 0);
  endtask

  task automatic rd(input int ch, input bit clr);
    step(1, 0, 0, 0, 0, 1, ch, clr);
  endtask

  initial begin
    // Reset, then read ch 3 -> INIT_VALUE one cycle later.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rd(3, 0);
    idle();

    // Wrap: ch 2 -> 250, +10 wraps to 4.
    inc(0, 2, 245);
    inc(0, 2, 10);
    rd(2, 0);
    idle();

    // Saturate: ch 2 back to 250, +10 clips at 255, +0 leaves it without a pulse.
    rd(2, 1);
    inc(1, 2, 250);
    inc(1, 2, 10);
    inc(1, 2, 0);
    rd(2, 0);
    idle();

    // Clear-on-read colliding with an increment on the same channel.
    rd(1, 1);
    inc(0, 1, 100);
    step(1, 0, 1, 1, 7, 1, 1, 1);
    rd(1, 0);
    idle();

    // Back-to-back increments on ch 0/1 with interleaved reads.
    rd(0, 1);
    rd(1, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 1, i % 2, 1, 1, (i + 1) % 2, 0);
    rd(0, 0);
    rd(1, 0);
    idle();

    // Out-of-range channels are ignored; read returns 0 with valid.
    inc(0, 6, 9);
    inc(0, 7, 200);
    rd(7, 0);
    rd(6, 1);
    step(1, 0, 1, 0, 3, 1, 0, 0);

    // Reset mid-read: request dropped, all channels back to INIT_VALUE.
    rd(4, 0);
    step(0, 0, 1, 4, 9, 1, 4, 1);
    idle();
    for (int c = 0; c < NCH; c++) rd(c, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                             : $urandom_range(0, 40),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 4) == 0);
    end
    for (int c = 0; c < NCH; c++) rd(c, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
